// File: rtl/wb_timer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_timer_pkg
// Description : Register map, CTRL bit positions, reset values and the
//               byte-lane merge helper shared by the Wishbone timer.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_timer_pkg;

    // Word offsets decoded from wb_adr_i[4:2]
    localparam logic [2:0] ADR_CTRL     = 3'd0;
    localparam logic [2:0] ADR_PRESCALE = 3'd1;
    localparam logic [2:0] ADR_COUNT    = 3'd2;
    localparam logic [2:0] ADR_CMP      = 3'd3;
    localparam logic [2:0] ADR_STATUS   = 3'd4;

    // CTRL register layout
    localparam int CTRL_W        = 3;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_AUTO_RLD = 2;

    // Compare register comes out of reset at all-ones so a fresh counter
    // does not match immediately.
    localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

    // Replace only the bytes whose lane enable is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage : wb_timer_pkg
`default_nettype wire

// File: rtl/wb_timer_prescaler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_timer_prescaler
// Description : Divides the system clock by (prescale+1) and emits a
//               single-cycle tick; held in reset while disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  load_clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] C_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    // Tick on the cycle the counter has reached the programmed terminal value
    assign tick = en && (pcnt_q == prescale);

    // Next prescale count: cleared when disabled, reprogrammed or wrapping
    always_comb begin
        pcnt_d = pcnt_q;
        if (!en || load_clr) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + C_ONE;
        end
    end

    // Prescale counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule : wb_timer_prescaler
`default_nettype wire

// File: rtl/wb_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_timer
// Description : Wishbone classic slave timer: prescaled 32-bit up-counter,
//               32-bit compare, sticky match flag, level irq, auto-reload.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        irq_o
);

    // Registers
    logic [CTRL_W-1:0]     ctrl_q,     ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           count_q,    count_d;
    logic [31:0]           cmp_q,      cmp_d;
    logic                  match_q,    match_d;
    logic                  ack_q,      ack_d;
    logic                  err_q,      err_d;
    logic [31:0]           dat_q,      dat_d;

    // Decode / datapath wires
    logic [2:0]  w_off;
    logic        w_req;
    logic        w_mapped;
    logic        w_wr;
    logic        w_tick;
    logic        w_hit;
    logic        w_prescale_wr;
    logic [31:0] w_rdata;
    logic        w_unused_ok;

    // Only the word-offset bits take part in decoding
    assign w_unused_ok = &{1'b0, wb_adr_i[31:5], wb_adr_i[1:0]};

    assign w_off         = wb_adr_i[4:2];
    assign w_req         = wb_cyc_i && wb_stb_i && !ack_q && !err_q;
    assign w_mapped      = (w_off <= ADR_STATUS);
    assign w_wr          = w_req && w_mapped && wb_we_i;
    assign w_prescale_wr = w_wr && (w_off == ADR_PRESCALE);
    // Compare always sees the register values from before any same-cycle write
    assign w_hit         = w_tick && (count_q == cmp_q);

    wb_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (ctrl_q[CTRL_EN]),
        .load_clr (w_prescale_wr),
        .prescale (prescale_q),
        .tick     (w_tick)
    );

    // Read-data multiplexer; unused bits and unmapped offsets read as zero
    always_comb begin
        w_rdata = '0;
        case (w_off)
            ADR_CTRL:     w_rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
            ADR_PRESCALE: w_rdata = 32'(prescale_q);
            ADR_COUNT:    w_rdata = count_q;
            ADR_CMP:      w_rdata = cmp_q;
            ADR_STATUS:   w_rdata = {31'b0, match_q};
            default:      w_rdata = '0;
        endcase
    end

    // Bus response, register writes, counter and match update
    always_comb begin
        ack_d      = w_req && w_mapped;
        err_d      = w_req && !w_mapped;
        dat_d      = (w_req && w_mapped && !wb_we_i) ? w_rdata : 32'd0;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        cmp_d      = cmp_q;
        match_d    = match_q;

        // Counter advance; a match either reloads or keeps counting
        if (w_tick) begin
            if (w_hit && ctrl_q[CTRL_AUTO_RLD]) begin
                count_d = 32'd0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (w_wr) begin
            case (w_off)
                ADR_CTRL: begin
                    if (wb_sel_i[0]) begin
                        ctrl_d = wb_dat_i[CTRL_W-1:0];
                    end
                end
                ADR_PRESCALE: begin
                    for (int i = 0; i < PRESCALE_W; i++) begin
                        if (wb_sel_i[i/8]) begin
                            prescale_d[i] = wb_dat_i[i];
                        end
                    end
                end
                // Bus write takes precedence over the tick update
                ADR_COUNT: count_d = byte_merge(count_q, wb_dat_i, wb_sel_i);
                ADR_CMP:   cmp_d   = byte_merge(cmp_q, wb_dat_i, wb_sel_i);
                ADR_STATUS: begin
                    if (wb_sel_i[0] && wb_dat_i[0]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A new match wins over a same-cycle write-1-to-clear
        if (w_hit) begin
            match_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            cmp_q      <= CMP_RST;
            match_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            match_q    <= match_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;
    assign irq_o    = match_q && ctrl_q[CTRL_IRQ_EN];

endmodule : wb_timer
`default_nettype wire

// File: tb/tb_wb_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wb_timer
// Description : Self-checking bench for wb_timer: cycle-level reference model
//               compared every cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_timer;

    localparam int          PW    = 16;
    localparam logic [31:0] PMASK = (32'd1 << PW) - 32'd1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_timer #(.PRESCALE_W(PW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .irq_o    (irq_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]  ctrl;     // {auto_rld, irq_en, en}
        logic [31:0] prescale;
        logic [31:0] count;
        logic [31:0] cmp;
        logic        match;
        logic [31:0] phase;    // cycles elapsed in the current prescale period
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } mstate_t;

    function automatic mstate_t m_reset();
        mstate_t r;
        r = '0;
        r.cmp = 32'hFFFF_FFFF;
        return r;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input mstate_t m, input int off);
        case (off)
            0: return {29'b0, m.ctrl};
            1: return m.prescale;
            2: return m.count;
            3: return m.cmp;
            4: return {31'b0, m.match};
            default: return 32'd0;
        endcase
    endfunction

    function automatic mstate_t m_step(input mstate_t m, input logic [31:0] adr, input logic [31:0] d,
                                       input logic [3:0] s, input logic we, input logic cyc, input logic stb);
        mstate_t n;
        int      off;
        bit      req, wr, tick, hit;
        n    = m;
        off  = int'(adr[4:2]);
        req  = cyc && stb && !m.ack && !m.err;
        wr   = req && (off < 5) && we;
        tick = m.ctrl[0] && (m.phase == m.prescale);
        hit  = tick && (m.count == m.cmp);
        n.ack = req && (off < 5);
        n.err = req && (off >= 5);
        n.dat = (req && off < 5 && !we) ? m_read(m, off) : 32'd0;
        if (!m.ctrl[0] || (wr && off == 1)) n.phase = 0;
        else n.phase = tick ? 32'd0 : m.phase + 1;
        if (tick) n.count = (hit && m.ctrl[2]) ? 32'd0 : m.count + 1;
        if (wr) begin
            case (off)
                0: n.ctrl     = lanes({29'b0, m.ctrl}, d, s) & 32'h7;
                1: n.prescale = lanes(m.prescale, d, s) & PMASK;
                2: n.count    = lanes(m.count, d, s);
                3: n.cmp      = lanes(m.cmp, d, s);
                4: if (s[0] && d[0]) n.match = 1'b0;
                default: ;
            endcase
        end
        if (hit) n.match = 1'b1;
        return n;
    endfunction

    mstate_t m;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= m_reset();
        else          m <= m_step(m, wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i);
    end

    // Compare DUT outputs against the model every cycle
    always @(negedge clk) begin
        check("ack_o", {31'b0, wb_ack_o}, {31'b0, m.ack});
        check("err_o", {31'b0, wb_err_o}, {31'b0, m.err});
        check("dat_o", wb_dat_o, m.dat);
        check("irq_o", {31'b0, irq_o}, {31'b0, m.match & m.ctrl[1]});
    end

    // ---------------- bus helpers ----------------
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic ack, output logic err);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = d;    wb_sel_i = s;
        @(posedge clk);
        #1;
        rd = wb_dat_o; ack = wb_ack_o; err = wb_err_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; logic ack, err;
        bus(1'b1, adr, d, s, rd, ack, err);
        check("wr_ack", {31'b0, ack}, 32'd1);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd; logic ack, err;
        bus(1'b0, adr, 32'd0, 4'h0, rd, ack, err);
        check({name, "_ack"}, {31'b0, ack}, 32'd1);
        check(name, rd, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] rd; logic ack, err;
        int n, acks;

        // 1: reset state
        idle(3);
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_err", {31'b0, wb_err_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_irq", {31'b0, irq_o}, 32'd0);
        reset_n = 1'b1;
        rd_chk("rst_cmp", 32'h0C, 32'hFFFF_FFFF);
        bus(1'b0, 32'h1C, 32'd0, 4'h0, rd, ack, err);
        check("unmapped_err", {31'b0, err}, 32'd1);
        check("unmapped_ack", {31'b0, ack}, 32'd0);

        // 2: byte lanes
        wr(32'h0C, 32'h0, 4'hF);
        wr(32'h0C, 32'hAABB_CCDD, 4'b0101);
        rd_chk("lanes_cmp", 32'h0C, 32'h00BB_00DD);

        // 3: count and match, PRESCALE=3 -> tick every 4 cycles; COUNT==5 at 6th tick
        wr(32'h04, 32'd3, 4'hF);
        wr(32'h0C, 32'd5, 4'hF);
        wr(32'h00, 32'h3, 4'hF);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (irq_o) break;
        end
        check("irq_delay", 32'(n), 32'd24);
        rd_chk("count_after_match", 32'h08, 32'd6);
        rd_chk("status_set", 32'h10, 32'd1);
        wr(32'h00, 32'h0, 4'hF);
        wr(32'h10, 32'h1, 4'hF);
        check("irq_cleared", {31'b0, irq_o}, 32'd0);
        rd_chk("status_clr", 32'h10, 32'd0);

        // 4: auto-reload, CMP=2, PRESCALE=0 -> COUNT 1,2,0,1,2,0...
        wr(32'h08, 32'd0, 4'hF);
        wr(32'h0C, 32'd2, 4'hF);
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h00, 32'h7, 4'hF);
        rd_chk("rld_c0", 32'h08, 32'd1);
        rd_chk("rld_c1", 32'h08, 32'd0);
        rd_chk("rld_c2", 32'h08, 32'd2);
        rd_chk("rld_c3", 32'h08, 32'd1);
        idle(2);
        wr(32'h10, 32'h1, 4'hF);          // lands on a match tick
        rd_chk("set_wins", 32'h10, 32'd1);
        wr(32'h10, 32'h1, 4'hF);          // lands on a non-match tick
        rd_chk("w1c_clears", 32'h10, 32'd0);

        // 5: wrap and write priority
        wr(32'h00, 32'h0, 4'hF);
        wr(32'h0C, 32'h100, 4'hF);
        wr(32'h08, 32'hFFFF_FFFE, 4'hF);
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h10, 32'h1, 4'hF);
        wr(32'h00, 32'h1, 4'hF);
        rd_chk("wrap_ff", 32'h08, 32'hFFFF_FFFF);
        rd_chk("wrap_1", 32'h08, 32'd1);
        wr(32'h04, 32'd3, 4'hF);
        idle(2);
        wr(32'h08, 32'h10, 4'hF);         // same edge as a tick
        rd_chk("count_wr_wins", 32'h08, 32'h10);

        // 6: protocol
        wr(32'h00, 32'h0, 4'hF);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (wb_ack_o) acks++;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("b2b_acks", 32'(acks), 32'd3);
        idle(1);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h0C;
        @(posedge clk); #1;
        check("pre_rst_ack", {31'b0, wb_ack_o}, 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ack", {31'b0, wb_ack_o}, 32'd0);
        idle(2);
        reset_n = 1'b1;
        rd_chk("post_rst_cmp", 32'h0C, 32'hFFFF_FFFF);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wb_timer
`default_nettype wire
